pg_vector_generator: RTL and testbench
======================================

PG_VECTOR_GENERATOR -- requirements
Module: pg_vector_generator

Interface
REQ-001 Parameters: none; all widths are fixed by package constants PG_LSB=14, PG_MSB=63, ROW_W=64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 row_a  input  64  sum row from the partial-product reduction tree.
REQ-005 row_b  input  64  carry row from the reduction tree, already aligned to row_a weights.
REQ-006 in_valid  input  1  row_a/row_b are valid this cycle.
REQ-007 in_ready  output  1  block accepts the rows this cycle.
REQ-008 prop  output  50 [63:14]  carry-chain select vector for the 50-bit carry-chain final adder.
REQ-009 gen  output  50 [63:14]  carry-chain data-in vector for the same adder.
REQ-010 cin  output  1  carry into bit 14 of the adder.
REQ-011 out_valid  output  1  prop/gen/cin are valid this cycle.
REQ-012 out_ready  input  1  downstream adder stage consumes the output this cycle.
REQ-013 xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-014 The block SHALL be a two-stage elastic pipeline: S1 registers the rows, S2 registers prop/gen/cin.
REQ-015 A transfer SHALL occur on in_valid&in_ready at input and on out_valid&out_ready at output.
REQ-016 S2 SHALL advance when it is empty or out_ready=1; S1 SHALL advance when it is empty or S2 advances.
REQ-017 in_ready SHALL equal (S1 empty) OR (S2 empty) OR out_ready.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when no stall occurs; throughput SHALL be 1 transfer per cycle.
REQ-019 For each i in 14..63: prop[i] SHALL be row_a[i] XOR row_b[i]; gen[i] SHALL be row_a[i] AND row_b[i].
REQ-020 Under backpressure (out_valid=1, out_ready=0), prop/gen/cin/out_valid SHALL hold stable; no data SHALL be dropped or duplicated.
REQ-021 Simultaneous input and output transfers in the same cycle SHALL both take effect.
REQ-022 xfer_cnt SHALL increment by 1 per output transfer and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-023 On rst: both stages empty, out_valid=0, prop=0, gen=0, cin=0, xfer_cnt=0.
REQ-024 in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-025 Assertion of rst mid-transfer SHALL discard all in-flight data immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro PG_LOWBIT_COMP_EN.
- Defined: cin SHALL be (a13&b13) | ((a13^b13)&(a12&b12)) over the S1-registered rows.
- Undefined: cin SHALL be constant 0 and row bits [13:0] SHALL be unused.

Structure
REQ-027 Package fabm_pg_pkg SHALL hold PG_LSB, PG_MSB, PG_W=50, ROW_W, and a struct type for the {prop, gen, cin} payload.
REQ-028 Sub-module pg_pipe_stage: a generic valid/ready register slice, instantiated for S1 and S2.

Verification
REQ-029 Basic path: row_a=64'hC000, row_b=64'h4000, out_ready=1.
- Two cycles later: prop=50'h2, gen=50'h1.
- cin=0.
REQ-030 Low-bit compensation: row_a=64'h3000, row_b=64'h1000.
- With PG_LOWBIT_COMP_EN: cin=1.
- Without it: cin=0.
- In both builds: prop=0, gen=0.
REQ-031 Backpressure: stream 4 vectors with out_ready=0.
- After 2 accepts, in_ready=0 and the output holds.
- Release out_ready: 4 vectors emerge in order, xfer_cnt=4.
REQ-032 Back-to-back: 100 random vectors with in_valid=1 and out_ready=1 constantly.
- One output per cycle.
- Every prop/gen matches REQ-019.
REQ-033 Async reset: assert rst between clock edges with 2 vectors in flight.
- out_valid=0 immediately.
- No stale vector appears after release.
REQ-034 Counter wrap: preload or stream 65536 transfers; xfer_cnt returns to 0.

Source files
------------

// File: rtl/pg_vector_generator_pkg.sv
// Shared widths, payload types and the P/G encoder for pg_vector_generator.
// PG_LOWBIT_COMP_EN widens the S1 row slice by two bits to feed cin.
package fabm_pg_pkg;
   localparam int PG_LSB = 14;
   localparam int PG_MSB = 63;
   localparam int ROW_W  = 64;
   localparam int PG_W   = PG_MSB - PG_LSB + 1;

`ifdef PG_LOWBIT_COMP_EN
   localparam int S1_LSB = PG_LSB - 2;
`else
   localparam int S1_LSB = PG_LSB;
`endif
   localparam int S1_W = PG_MSB - S1_LSB + 1;

   typedef struct packed {
      logic [PG_W-1:0] prop;
      logic [PG_W-1:0] gen;
      logic            cin;
   } pg_payload_t;

   typedef struct packed {
      logic [S1_W-1:0] a;
      logic [S1_W-1:0] b;
   } pg_rows_t;

   // The low two slice bits (when present) are row bits 13 and 12.
   function automatic pg_payload_t pg_encode(input pg_rows_t r);
      pg_payload_t p;
      p.prop = r.a[S1_W-1 -: PG_W] ^ r.b[S1_W-1 -: PG_W];
      p.gen  = r.a[S1_W-1 -: PG_W] & r.b[S1_W-1 -: PG_W];
`ifdef PG_LOWBIT_COMP_EN
      p.cin  = (r.a[1] & r.b[1]) | ((r.a[1] ^ r.b[1]) & (r.a[0] & r.b[0]));
`else
      p.cin  = 1'b0;
`endif
      return p;
   endfunction
endpackage

// File: rtl/pg_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module pg_pipe_stage #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);
   logic         r_valid;
   logic [W-1:0] r_data;

   assign o_ready = ~r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) r_data <= i_data;
      end
   end
endmodule

// File: rtl/pg_vector_generator.sv
// Two-stage elastic pipeline turning sum/carry rows into prop/gen/cin.
// Build option PG_LOWBIT_COMP_EN enables cin from row bits 13:12.
module pg_vector_generator
   import fabm_pg_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ROW_W-1:0]        row_a,
   input  logic [ROW_W-1:0]        row_b,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [PG_MSB:PG_LSB]    prop,
   output logic [PG_MSB:PG_LSB]    gen,
   output logic                    cin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             xfer_cnt
);
   localparam int S1_DW = $bits(pg_rows_t);
   localparam int S2_DW = $bits(pg_payload_t);

   pg_rows_t    w_s1_in, w_s1_out;
   pg_payload_t w_s2_in, w_s2_out;
   logic        w_s1_valid, w_s2_ready;
   logic        w_unused_lo;
   logic [15:0] r_xfer_cnt;

   assign w_s1_in.a   = row_a[PG_MSB:S1_LSB];
   assign w_s1_in.b   = row_b[PG_MSB:S1_LSB];
   assign w_unused_lo = ^{row_a[S1_LSB-1:0], row_b[S1_LSB-1:0]};

   pg_pipe_stage #(.W(S1_DW)) u_s1 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_s1_in),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_ready),
      .o_data  (w_s1_out)
   );

   assign w_s2_in = pg_encode(w_s1_out);

   pg_pipe_stage #(.W(S2_DW)) u_s2 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_ready),
      .i_data  (w_s2_in),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_s2_out)
   );

   assign prop     = w_s2_out.prop;
   assign gen      = w_s2_out.gen;
   assign cin      = w_s2_out.cin;
   assign xfer_cnt = r_xfer_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_xfer_cnt <= '0;
      else if (out_valid && out_ready) r_xfer_cnt <= r_xfer_cnt + 16'd1;
   end
endmodule

// File: tb/tb_pg_vector_generator.sv
// Directed bench for pg_vector_generator: reset, P/G encoding, backpressure,
// back-to-back streaming, async reset flush and transfer-counter wrap.
module tb_pg_vector_generator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] row_a, row_b;
   logic        in_valid, in_ready;
   logic [63:14] prop, gen;
   logic        cin, out_valid, out_ready;
   logic [15:0] xfer_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;
   logic [100:0] q[$];

   always #5 clk = ~clk;

   pg_vector_generator dut (
      .clk(clk), .rst(rst), .row_a(row_a), .row_b(row_b),
      .in_valid(in_valid), .in_ready(in_ready),
      .prop(prop), .gen(gen), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   wire [100:0] w_out = {prop, gen, cin};

   function automatic logic [100:0] model(input logic [63:0] a, input logic [63:0] b);
      logic c;
`ifdef PG_LOWBIT_COMP_EN
      c = (a[13] & b[13]) | ((a[13] ^ b[13]) & (a[12] & b[12]));
`else
      c = 1'b0;
`endif
      return {a[63:14] ^ b[63:14], a[63:14] & b[63:14], c};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // Called at a negedge with inputs set; scores both handshakes, ends at next negedge.
   task automatic tick(output bit acc);
      #1;
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) chk("out_without_input", out_valid, 1'b0);
         else               chk("out_order", w_out, q.pop_front());
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(row_a, row_b));
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          idx, nacc, n0;
      logic [63:0] va[4], vb[4];
      logic        exp_cin;

      va[0] = 64'hF0F0_1234_5678_C000; vb[0] = 64'h0FF0_8765_4321_4000;
      va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0000_0000_0000_0000;
      va[2] = 64'hAAAA_AAAA_AAAA_AAAA; vb[2] = 64'hFFFF_0000_FFFF_0000;
      va[3] = 64'h8000_0000_0000_4000; vb[3] = 64'h8000_0000_0000_4000;

      in_valid = 1'b0; out_ready = 1'b0; row_a = '0; row_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_prop", prop, 50'h0);
      chk("rst_gen", gen, 50'h0);
      chk("rst_cin", cin, 1'b0);
      chk("rst_xfer_cnt", xfer_cnt, 16'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);

      // Basic path: 2-cycle latency, hand-computed P/G
      row_a = 64'hC000; row_b = 64'h4000; in_valid = 1'b1; out_ready = 1'b1;
      tick(acc);
      in_valid = 1'b0;
      tick(acc);
      chk("basic_out_valid", out_valid, 1'b1);
      chk("basic_prop", prop, 50'h2);
      chk("basic_gen", gen, 50'h1);
      chk("basic_cin", cin, 1'b0);
      tick(acc);
      chk("basic_xfer_cnt", xfer_cnt, 16'd1);

      // Low-bit compensation
`ifdef PG_LOWBIT_COMP_EN
      exp_cin = 1'b1;
`else
      exp_cin = 1'b0;
`endif
      row_a = 64'h3000; row_b = 64'h1000; in_valid = 1'b1;
      tick(acc);
      in_valid = 1'b0;
      tick(acc);
      chk("lowbit_out_valid", out_valid, 1'b1);
      chk("lowbit_prop", prop, 50'h0);
      chk("lowbit_gen", gen, 50'h0);
      chk("lowbit_cin", cin, exp_cin);
      tick(acc);
      chk("lowbit_xfer_cnt", xfer_cnt, 16'd2);

      // Backpressure: two accepts fill both stages, then the output holds
      out_ready = 1'b0; idx = 0;
      for (int c = 0; c < 10 && idx < 2; c++) begin
         row_a = va[idx]; row_b = vb[idx]; in_valid = 1'b1;
         tick(acc);
         if (acc) idx++;
      end
      chk("bp_two_accepts", idx, 2);
      row_a = va[2]; row_b = vb[2];
      for (int c = 0; c < 3; c++) begin
         chk("bp_in_ready_low", in_ready, 1'b0);
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_data", w_out, model(va[0], vb[0]));
         tick(acc);
         if (acc) idx++;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
         if (idx < 4) begin
            row_a = va[idx]; row_b = vb[idx]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         tick(acc);
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("bp_outputs", n_out, 6);
      chk("bp_xfer_cnt", xfer_cnt, 16'd6);

      // Back-to-back random stream
      nacc = 0; n0 = n_out;
      for (int c = 0; c < 102; c++) begin
         if (c < 100) begin
            row_a = {$urandom, $urandom}; row_b = {$urandom, $urandom}; in_valid = 1'b1;
         end else in_valid = 1'b0;
         tick(acc);
         if (acc) nacc++;
         if (c >= 1 && c <= 100) chk("b2b_out_valid", out_valid, 1'b1);
      end
      chk("b2b_accepts", nacc, 100);
      chk("b2b_outputs", n_out - n0, 100);
      chk("b2b_xfer_cnt", xfer_cnt, 16'd106);

      // Async reset between edges with two vectors in flight
      out_ready = 1'b0;
      row_a = va[2]; row_b = vb[2]; in_valid = 1'b1;
      tick(acc);
      row_a = va[3]; row_b = vb[3];
      tick(acc);
      in_valid = 1'b0;
      chk("ar_pre_valid", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 1'b0);
      chk("ar_prop", prop, 50'h0);
      chk("ar_xfer_cnt", xfer_cnt, 16'h0);
      q.delete();
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1; n0 = n_out;
      for (int c = 0; c < 5; c++) begin
         tick(acc);
         chk("ar_no_stale", out_valid, 1'b0);
      end
      chk("ar_no_outputs", n_out - n0, 0);

      // Counter wrap over 65536 transfers
      row_a = 64'h1; row_b = 64'h2; in_valid = 1'b1;
      repeat (65536) @(negedge clk);
      in_valid = 1'b0;
      chk("wrap_fffe", xfer_cnt, 16'hFFFE);
      @(negedge clk);
      chk("wrap_ffff", xfer_cnt, 16'hFFFF);
      @(negedge clk);
      chk("wrap_zero", xfer_cnt, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
